rv64wb: RTL and testbench

Write-back arbiter and scoreboard driving the integer register file's single write port. Arbitrates results from the ALU and the LSU onto that port with valid/ready handshakes. Tracks outstanding destination registers so decode can stall on read-after-write hazards. Sits between the execute/memory stages and the register file.

---
 rtl/rv64wb_pkg.sv | 33 +++
 rtl/rv64wb_scoreboard.sv | 51 +++++
 rtl/rv64wb.sv | 94 +++++++++
 tb/tb_rv64wb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64wb_pkg.sv
// Shared configuration and helpers for the rv64wb write-back arbiter and scoreboard.
// Holds the system sizing and the pending-counter update rule.
package rv64wb_pkg;

    localparam int XLEN_DEF          = 64;
    localparam int REG_ADDRWIDTH_DEF = 5;
    localparam int REG_NUM           = 32;

    localparam int CNT_W        = 2;
    localparam int STREAK_W     = 2;
    localparam int STREAK_LIMIT = 2;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LSU  = 2'd2
    } grant_e;

    // Simultaneous issue and retire on one register cancel out; the counter wraps otherwise.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            res = cnt - CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/rv64wb_scoreboard.sv
// Per-register pending-write counters with combinational busy lookup for two sources.
// Register 0 is never tracked and always reads idle.
module rv64wb_scoreboard
    import rv64wb_pkg::*;
#(
    parameter int REG_ADDRWIDTH = REG_ADDRWIDTH_DEF,
    parameter int NUM_REGS      = REG_NUM
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [REG_ADDRWIDTH-1:0] issue_rd,
    input  logic                     clr_valid,
    input  logic [REG_ADDRWIDTH-1:0] clr_idx,
    input  logic [REG_ADDRWIDTH-1:0] rs1_idx,
    input  logic [REG_ADDRWIDTH-1:0] rs2_idx,
    output logic                     rs1_busy,
    output logic                     rs2_busy
);

    logic [CNT_W-1:0]    count [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_valid && (issue_rd != '0)) begin
            inc_vec[issue_rd] = 1'b1;
        end
        if (clr_valid) begin
            dec_vec[clr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                count[i] <= cnt_next(count[i], inc_vec[i], dec_vec[i]);
            end
        end
    end

    assign rs1_busy = (rs1_idx != '0) && (count[rs1_idx] != '0);
    assign rs2_busy = (rs2_idx != '0) && (count[rs2_idx] != '0);

endmodule

// File: rtl/rv64wb.sv
// Write-back arbiter: merges ALU and LSU results onto the single register-file write port
// and tracks outstanding destinations so decode can stall on RAW hazards.
module rv64wb
    import rv64wb_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int REG_ADDRWIDTH = REG_ADDRWIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [REG_ADDRWIDTH-1:0] issue_rd,
    input  logic [REG_ADDRWIDTH-1:0] rs1_idx,
    input  logic [REG_ADDRWIDTH-1:0] rs2_idx,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_ADDRWIDTH-1:0] alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [REG_ADDRWIDTH-1:0] lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    output logic [REG_ADDRWIDTH-1:0] wb_idx,
    output logic [XLEN-1:0]          wb_data,
    output logic                     wb_wen
);

    localparam int NUM_REGS = 1 << REG_ADDRWIDTH;

    logic [STREAK_W-1:0]      lsu_streak;
    logic [STREAK_W-1:0]      streak_next;
    logic                     alu_turn;
    grant_e                   grant;
    logic [REG_ADDRWIDTH-1:0] grant_rd;
    logic [XLEN-1:0]          grant_data;

    // The ALU is forced through once the LSU has won twice in a row against it.
    assign alu_turn  = alu_valid && (lsu_streak == STREAK_W'(STREAK_LIMIT));
    assign lsu_ready = lsu_valid & ~alu_turn;
    assign alu_ready = alu_valid & ~lsu_ready;

    always_comb begin
        grant       = GRANT_NONE;
        grant_rd    = alu_rd;
        grant_data  = alu_data;
        streak_next = '0;
        if (lsu_ready) begin
            grant      = GRANT_LSU;
            grant_rd   = lsu_rd;
            grant_data = lsu_data;
            if (alu_valid) begin
                streak_next = lsu_streak + STREAK_W'(1);
            end
        end else if (alu_ready) begin
            grant = GRANT_ALU;
        end
    end

    // Write-back register stage: one cycle between handshake and register-file write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_streak <= '0;
            wb_wen     <= 1'b0;
            wb_idx     <= '0;
            wb_data    <= '0;
        end else begin
            lsu_streak <= streak_next;
            wb_wen     <= (grant != GRANT_NONE) && (grant_rd != '0);
            if (grant != GRANT_NONE) begin
                wb_idx  <= grant_rd;
                wb_data <= grant_data;
            end
        end
    end

    rv64wb_scoreboard #(
        .REG_ADDRWIDTH (REG_ADDRWIDTH),
        .NUM_REGS      (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .clr_valid   (wb_wen),
        .clr_idx     (wb_idx),
        .rs1_idx     (rs1_idx),
        .rs2_idx     (rs2_idx),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

endmodule

// File: tb/tb_rv64wb.sv
// Directed self-checking bench for rv64wb: reset, single op, contention, x0,
// repeated destination and backpressure scenarios.
module tb_rv64wb;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic [4:0]  wb_idx;
    logic [63:0] wb_data;
    logic        wb_wen;

    int total;
    int passed;

    rv64wb #(
        .XLEN          (64),
        .REG_ADDRWIDTH (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_idx     (rs1_idx),
        .rs2_idx     (rs2_idx),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .wb_idx      (wb_idx),
        .wb_data     (wb_data),
        .wb_wen      (wb_wen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        total++; if (wb_wen !== 1'b0) $display("FAIL reset_wb_wen: got %b want 0", wb_wen); else passed++;
        total++; if (wb_idx !== 5'd0) $display("FAIL reset_wb_idx: got %0d want 0", wb_idx); else passed++;
        total++; if (wb_data !== 64'd0) $display("FAIL reset_wb_data: got %h want 0", wb_data); else passed++;
        tick();
        rst_n = 1'b1;
        rs1_idx = 5'd6;
        rs2_idx = 5'd8;
        #1;
        total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
            $display("FAIL reset_busy_initial: got %b%b want 00", rs1_busy, rs2_busy); else passed++;
        issue_valid = 1'b1;
        issue_rd = 5'd6;
        tick();
        issue_rd = 5'd8;
        alu_valid = 1'b1;
        alu_rd = 5'd6;
        alu_data = 64'h55;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b0;
        total++; if (wb_wen !== 1'b1) $display("FAIL reset_pre_wen: got %b want 1", wb_wen); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (wb_wen !== 1'b0) $display("FAIL reset_async_wen: got %b want 0", wb_wen); else passed++;
        total++; if (wb_idx !== 5'd0 || wb_data !== 64'd0)
            $display("FAIL reset_async_wb: got idx %0d data %h want 0/0", wb_idx, wb_data); else passed++;
        total++; if (rs2_busy !== 1'b0) $display("FAIL reset_async_busy8: got %b want 0", rs2_busy); else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
            $display("FAIL reset_release_busy: got %b%b want 00", rs1_busy, rs2_busy); else passed++;
        tick();
    endtask

    task automatic test_single_alu();
        issue_valid = 1'b1;
        issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd5;
        alu_data = 64'h1234;
        rs1_idx = 5'd5;
        #1;
        total++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0)
            $display("FAIL single_ready: got alu %b lsu %b want 1/0", alu_ready, lsu_ready); else passed++;
        total++; if (rs1_busy !== 1'b1) $display("FAIL single_busy_n: got %b want 1", rs1_busy); else passed++;
        tick();
        alu_valid = 1'b0;
        #1;
        total++; if (wb_wen !== 1'b1 || wb_idx !== 5'd5 || wb_data !== 64'h1234)
            $display("FAIL single_wb: got wen %b idx %0d data %h want 1/5/1234", wb_wen, wb_idx, wb_data); else passed++;
        total++; if (rs1_busy !== 1'b1) $display("FAIL single_busy_n1: got %b want 1", rs1_busy); else passed++;
        tick();
        total++; if (rs1_busy !== 1'b0) $display("FAIL single_busy_n2: got %b want 0", rs1_busy); else passed++;
        total++; if (wb_wen !== 1'b0 || wb_idx !== 5'd5 || wb_data !== 64'h1234)
            $display("FAIL single_hold: got wen %b idx %0d data %h want 0/5/1234", wb_wen, wb_idx, wb_data); else passed++;
    endtask

    task automatic test_contention();
        bit         exp_lsu [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [4:0] exp_rd  [5] = '{5'd1, 5'd2, 5'd9, 5'd3, 5'd4};
        logic [4:0] regs    [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
        int         li;
        bit         alu_done;
        logic [63:0] exp_data;
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1;
            issue_rd = regs[i];
            tick();
        end
        issue_valid = 1'b0;
        li = 0;
        alu_done = 1'b0;
        alu_rd = 5'd9;
        alu_data = 64'h900;
        for (int c = 0; c < 5; c++) begin
            lsu_valid = (li < 4);
            lsu_rd = 5'(li + 1);
            lsu_data = 64'h100 + 64'(li + 1);
            alu_valid = !alu_done;
            #1;
            total++; if (lsu_ready !== exp_lsu[c] || alu_ready !== !exp_lsu[c])
                $display("FAIL contention_grant%0d: got lsu %b alu %b want lsu %b", c, lsu_ready, alu_ready, exp_lsu[c]);
            else passed++;
            if (lsu_ready) li++;
            if (alu_ready) alu_done = 1'b1;
            tick();
            exp_data = (exp_rd[c] == 5'd9) ? 64'h900 : 64'h100 + 64'(exp_rd[c]);
            total++; if (wb_wen !== 1'b1 || wb_idx !== exp_rd[c] || wb_data !== exp_data)
                $display("FAIL contention_wb%0d: got wen %b idx %0d data %h want 1/%0d/%h",
                         c, wb_wen, wb_idx, wb_data, exp_rd[c], exp_data);
            else passed++;
        end
        lsu_valid = 1'b0;
        alu_valid = 1'b0;
        #1;
        total++; if (lsu_ready !== 1'b0 || alu_ready !== 1'b0)
            $display("FAIL contention_idle_ready: got lsu %b alu %b want 0/0", lsu_ready, alu_ready); else passed++;
        tick();
        rs1_idx = 5'd4;
        rs2_idx = 5'd9;
        #1;
        total++; if (wb_wen !== 1'b0) $display("FAIL contention_idle_wen: got %b want 0", wb_wen); else passed++;
        total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
            $display("FAIL contention_busy: got %b%b want 00", rs1_busy, rs2_busy); else passed++;
    endtask

    task automatic test_x0();
        issue_valid = 1'b1;
        issue_rd = 5'd0;
        rs1_idx = 5'd0;
        rs2_idx = 5'd0;
        #1;
        total++; if (rs1_busy !== 1'b0) $display("FAIL x0_busy_issue: got %b want 0", rs1_busy); else passed++;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd0;
        alu_data = 64'hdead;
        #1;
        total++; if (alu_ready !== 1'b1) $display("FAIL x0_alu_ready: got %b want 1", alu_ready); else passed++;
        total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
            $display("FAIL x0_busy: got %b%b want 00", rs1_busy, rs2_busy); else passed++;
        tick();
        alu_valid = 1'b0;
        #1;
        total++; if (wb_wen !== 1'b0) $display("FAIL x0_wen: got %b want 0", wb_wen); else passed++;
        tick();
        total++; if (wb_wen !== 1'b0) $display("FAIL x0_wen_after: got %b want 0", wb_wen); else passed++;
    endtask

    task automatic test_same_reg();
        rs1_idx = 5'd7;
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        tick();
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd7;
        alu_data = 64'h71;
        #1;
        total++; if (alu_ready !== 1'b1) $display("FAIL same_ready1: got %b want 1", alu_ready); else passed++;
        tick();
        alu_valid = 1'b0;
        #1;
        total++; if (wb_wen !== 1'b1 || wb_idx !== 5'd7)
            $display("FAIL same_wb1: got wen %b idx %0d want 1/7", wb_wen, wb_idx); else passed++;
        tick();
        total++; if (rs1_busy !== 1'b1) $display("FAIL same_busy_after_wb1: got %b want 1", rs1_busy); else passed++;
        alu_valid = 1'b1;
        alu_data = 64'h72;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        #1;
        total++; if (wb_wen !== 1'b1 || wb_data !== 64'h72)
            $display("FAIL same_wb2: got wen %b data %h want 1/72", wb_wen, wb_data); else passed++;
        tick();
        issue_valid = 1'b0;
        #1;
        total++; if (rs1_busy !== 1'b1) $display("FAIL same_busy_overlap: got %b want 1", rs1_busy); else passed++;
        alu_valid = 1'b1;
        alu_data = 64'h73;
        tick();
        alu_valid = 1'b0;
        #1;
        total++; if (rs1_busy !== 1'b1 || wb_data !== 64'h73)
            $display("FAIL same_wb3: got busy %b data %h want 1/73", rs1_busy, wb_data); else passed++;
        tick();
        total++; if (rs1_busy !== 1'b0) $display("FAIL same_busy_final: got %b want 0", rs1_busy); else passed++;
    endtask

    task automatic test_backpressure();
        logic [4:0] regs [4] = '{5'd10, 5'd11, 5'd12, 5'd13};
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_rd = regs[i];
            tick();
        end
        issue_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd12;
        alu_data = 64'hABCDEF0123456789;
        lsu_valid = 1'b1;
        lsu_rd = 5'd10;
        lsu_data = 64'hA0;
        #1;
        total++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0)
            $display("FAIL bp_cycle1: got lsu %b alu %b want 1/0", lsu_ready, alu_ready); else passed++;
        tick();
        lsu_rd = 5'd11;
        lsu_data = 64'hB0;
        #1;
        total++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0)
            $display("FAIL bp_cycle2: got lsu %b alu %b want 1/0", lsu_ready, alu_ready); else passed++;
        total++; if (wb_idx !== 5'd10 || wb_data !== 64'hA0)
            $display("FAIL bp_wb1: got idx %0d data %h want 10/a0", wb_idx, wb_data); else passed++;
        tick();
        lsu_rd = 5'd13;
        lsu_data = 64'hD0;
        #1;
        total++; if (lsu_ready !== 1'b0 || alu_ready !== 1'b1)
            $display("FAIL bp_cycle3: got lsu %b alu %b want 0/1", lsu_ready, alu_ready); else passed++;
        tick();
        alu_valid = 1'b0;
        #1;
        total++; if (wb_wen !== 1'b1 || wb_idx !== 5'd12 || wb_data !== 64'hABCDEF0123456789)
            $display("FAIL bp_alu_wb: got wen %b idx %0d data %h want 1/12/abcdef0123456789",
                     wb_wen, wb_idx, wb_data); else passed++;
        total++; if (lsu_ready !== 1'b1) $display("FAIL bp_lsu_resume: got %b want 1", lsu_ready); else passed++;
        tick();
        lsu_valid = 1'b0;
        #1;
        total++; if (wb_idx !== 5'd13 || wb_data !== 64'hD0)
            $display("FAIL bp_wb_last: got idx %0d data %h want 13/d0", wb_idx, wb_data); else passed++;
        tick();
        rs1_idx = 5'd12;
        rs2_idx = 5'd13;
        #1;
        total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
            $display("FAIL bp_busy: got %b%b want 00", rs1_busy, rs2_busy); else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b1;
        issue_valid = 1'b0;
        issue_rd = '0;
        rs1_idx = '0;
        rs2_idx = '0;
        alu_valid = 1'b0;
        alu_rd = '0;
        alu_data = '0;
        lsu_valid = 1'b0;
        lsu_rd = '0;
        lsu_data = '0;
        test_reset();
        test_single_alu();
        test_contention();
        test_x0();
        test_same_reg();
        test_backpressure();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
